// File: rtl/cell_bist_pkg.sv
// cell_bist_pkg: shared definitions for the 4-input cell BIST sequencer.
//   - state_t      : sequencer FSM states
//   - misr_taps()  : MISR feedback polynomial per signature width
//   - oai22_exp()  : golden OAI22 response for a {A0,A1,B0,B1} vector
//   - vec_of()     : step -> vector mapping (binary, or Gray when
//                    CELL_BIST_GRAY_ORDER_EN is defined)
package cell_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [31:0] MISR_TAPS_8  = 32'h0000_001D; // x^8+x^4+x^3+x^2+1
    localparam logic [31:0] MISR_TAPS_16 = 32'h0000_1021; // CCITT
    localparam logic [31:0] MISR_TAPS_24 = 32'h0086_4CFB; // CRC-24
    localparam logic [31:0] MISR_TAPS_32 = 32'h04C1_1DB7; // CRC-32

    // Widths without a listed polynomial fall back to the 8-bit taps, which
    // still give a usable (if not maximal-length) compactor.
    function automatic logic [31:0] misr_taps(input int unsigned w);
        case (w)
            8:       return MISR_TAPS_8;
            16:      return MISR_TAPS_16;
            24:      return MISR_TAPS_24;
            32:      return MISR_TAPS_32;
            default: return MISR_TAPS_8;
        endcase
    endfunction

    // vec = {A0,A1,B0,B1}
    function automatic logic oai22_exp(input logic [3:0] vec);
        return ~((vec[3] | vec[2]) & (vec[1] | vec[0]));
    endfunction

    function automatic logic [3:0] vec_of(input logic [3:0] step);
`ifdef CELL_BIST_GRAY_ORDER_EN
        return step ^ (step >> 1);
`else
        return step;
`endif
    endfunction

endpackage

// File: rtl/cell_bist_misr.sv
// cell_bist_misr: serial-input MISR with enable and synchronous clear.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (signature -> 0)
//   clr_i  : synchronous clear, has priority over en_i
//   en_i   : shift one serial bit in
//   din_i  : serial input bit
//   sig_o  : current signature
module cell_bist_misr #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] sig_o
);

    logic [WIDTH-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[WIDTH-2:0], 1'b0}
                  ^ (sig_q[WIDTH-1] ? TAPS : '0)
                  ^ {{(WIDTH-1){1'b0}}, din_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/cell_bist_4in.sv
// cell_bist_4in: BIST sequencer for a 4-input combinational cell (OAI22).
// Applies 16 vectors, waits SETTLE_CYCLES, samples Y_DUT against the golden
// model, counts mismatches and compresses all samples into a MISR.
// Ports:
//   CLK, RST         : clock, synchronous active-high reset
//   START            : begin a run (accepted in IDLE or DONE only)
//   A0,A1,B0,B1      : drive to the cell under test ({A0,A1,B0,B1} = vector)
//   Y_DUT            : cell output under test
//   BUSY, DONE, PASS : run status (PASS valid while DONE)
//   FAIL_CNT         : mismatching vectors, 0..16
//   FIRST_FAIL_VEC   : vector of the first mismatch, 0 if none
//   SIGNATURE        : MISR over sampled Y_DUT
// Build option: define CELL_BIST_GRAY_ORDER_EN for Gray vector order.
module cell_bist_4in
    import cell_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MISR_WIDTH    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  A0,
    output logic                  A1,
    output logic                  B0,
    output logic                  B1,
    input  logic                  Y_DUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [4:0]            FAIL_CNT,
    output logic [3:0]            FIRST_FAIL_VEC,
    output logic [MISR_WIDTH-1:0] SIGNATURE
);

    localparam logic [31:0]           TAPS_FULL   = misr_taps(MISR_WIDTH);
    localparam logic [MISR_WIDTH-1:0] TAPS        = TAPS_FULL[MISR_WIDTH-1:0];
    localparam logic [3:0]            SETTLE_LAST =
        4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] vec_q, vec_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] fail_q, fail_d;
    logic [3:0] first_q, first_d;
    logic       misr_clr, misr_en;
    logic       mismatch;

    // The driven vector is registered, so vec_q is exactly what the cell sees.
    assign mismatch = (Y_DUT != oai22_exp(vec_q));

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        busy_d   = busy_q;
        done_d   = done_q;
        fail_d   = fail_q;
        first_d  = first_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Vector outputs are left alone so DONE holds the last vector.
                if (START) begin
                    state_d  = ST_APPLY;
                    step_d   = '0;
                    fail_d   = '0;
                    first_d  = '0;
                    misr_clr = 1'b1;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            ST_APPLY: begin
                vec_d = vec_of(step_q);
                cnt_d = '0;
                if (SETTLE_CYCLES > 0) state_d = ST_SETTLE;
                else                   state_d = ST_SAMPLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
                else                      cnt_d   = cnt_q + 4'd1;
            end
            ST_SAMPLE: begin
                misr_en = 1'b1;
                if (mismatch) begin
                    if (fail_q < 5'd16) fail_d  = fail_q + 5'd1;
                    if (fail_q == '0)   first_d = vec_q;
                end
                if (step_q == 4'd15) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + 4'd1;
                    state_d = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            first_q <= first_d;
        end
    end

    cell_bist_misr #(
        .WIDTH (MISR_WIDTH),
        .TAPS  (TAPS)
    ) u_misr (
        .clk_i (CLK),
        .rst_i (RST),
        .clr_i (misr_clr),
        .en_i  (misr_en),
        .din_i (Y_DUT),
        .sig_o (SIGNATURE)
    );

    assign {A0, A1, B0, B1} = vec_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = done_q & (fail_q == '0);
    assign FAIL_CNT       = fail_q;
    assign FIRST_FAIL_VEC = first_q;

endmodule

// File: tb/tb_cell_bist_4in.sv
// Scoreboard bench for cell_bist_4in: a behavioural model predicts each run's
// results from a per-vector error mask; a monitor checks them when DONE rises.
module tb_cell_bist_4in;
    import cell_bist_pkg::misr_taps;

    localparam int W = 16;
    localparam logic [31:0] TF = misr_taps(W);

    typedef struct {
        int         fail;
        logic [3:0] first;
        logic [W-1:0] sig;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start1;
    logic a0, a1, b0, b1, y, busy, done, pass;
    logic [4:0] fcnt;
    logic [3:0] ffv;
    logic [W-1:0] sig;
    logic [15:0] mask;

    logic c0, c1, d0, d1, y1, busy1, done1, pass1;
    logic [4:0] fcnt1;
    logic [3:0] ffv1;
    logic [W-1:0] sig1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sb[$];

    // Cell model: OAI22 with a per-vector flip mask to inject faults.
    assign y  = (!((a0 || a1) && (b0 || b1))) ^ mask[{a0, a1, b0, b1}];
    assign y1 = !((c0 || c1) && (d0 || d1));

    cell_bist_4in #(.SETTLE_CYCLES(2), .MISR_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .START(start),
        .A0(a0), .A1(a1), .B0(b0), .B1(b1), .Y_DUT(y),
        .BUSY(busy), .DONE(done), .PASS(pass), .FAIL_CNT(fcnt),
        .FIRST_FAIL_VEC(ffv), .SIGNATURE(sig)
    );

    cell_bist_4in #(.SETTLE_CYCLES(0), .MISR_WIDTH(W)) dut0 (
        .CLK(clk), .RST(rst), .START(start1),
        .A0(c0), .A1(c1), .B0(d0), .B1(d1), .Y_DUT(y1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_CNT(fcnt1),
        .FIRST_FAIL_VEC(ffv1), .SIGNATURE(sig1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] order(input logic [3:0] s);
`ifdef CELL_BIST_GRAY_ORDER_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    function automatic bit gold(input logic [3:0] v);
        return !((v[3] || v[2]) && (v[1] || v[0]));
    endfunction

    function automatic logic [15:0] gold_mask();
        logic [15:0] m;
        for (int i = 0; i < 16; i++) m[i] = gold(4'(i));
        return m;
    endfunction

    // Walk the vector sequence: a vector fails exactly when its mask bit is
    // set; the signature is a polynomial division of the observed bits.
    function automatic exp_t model(input logic [15:0] m, input int settle);
        exp_t e;
        logic [W-1:0] taps;
        taps    = TF[W-1:0];
        e.fail  = 0;
        e.first = '0;
        e.sig   = '0;
        e.len   = 16 * (settle + 2);
        for (int s = 0; s < 16; s++) begin
            logic [3:0] v;
            bit yy, msb;
            v  = order(4'(s));
            yy = gold(v) ^ m[v];
            if (m[v]) begin
                if (e.fail == 0) e.first = v;
                e.fail++;
            end
            msb   = e.sig[W-1];
            e.sig = e.sig << 1;
            if (msb) e.sig = e.sig ^ taps;
            e.sig[0] = e.sig[0] ^ yy;
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: measure run length from BUSY rise, check results on DONE rise.
    logic busy_prev = 1'b0, done_prev = 1'b0;
    int   start_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_prev) start_cyc = cyc;
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("fail_cnt", 64'(fcnt), 64'(e.fail));
                chk("first_fail_vec", 64'(ffv), 64'(e.first));
                chk("signature", 64'(sig), 64'(e.sig));
                chk("pass", 64'(pass), 64'(e.fail == 0));
                chk("run_len", 64'(cyc - start_cyc), 64'(e.len));
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [15:0] m, input bit poke);
        mask = m;
        sb.push_back(model(m, 2));
        pulse_start();
        if (poke) begin
            // START while BUSY must not restart or stretch the run.
            repeat (10) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        exp_t e0;
        int n;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vec", 64'({a0, a1, b0, b1}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fail_cnt", 64'(fcnt), 64'd0);
        chk("rst_sig", 64'(sig), 64'd0);
        rst = 1'b0;

        run(16'h0000, 1'b0);       // good cell
        run(gold_mask(), 1'b0);    // Y stuck at 0
        run(~gold_mask(), 1'b0);   // Y stuck at 1
        run(16'hFFFF, 1'b1);       // inverted cell, plus START while BUSY

        // Abort mid-run: reset lands during SETTLE of step 7.
        mask = 16'hFFFF;
        pulse_start();
        repeat (29) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_vec", 64'({a0, a1, b0, b1}), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_pass", 64'(pass), 64'd0);
        chk("abort_fail_cnt", 64'(fcnt), 64'd0);
        chk("abort_first", 64'(ffv), 64'd0);
        chk("abort_sig", 64'(sig), 64'd0);
        rst = 1'b0;
        run(16'h0000, 1'b0);

        for (int i = 0; i < 6; i++) run(16'($urandom), i == 2);

        // Zero-settle instance: 2 cycles per vector.
        e0 = model(16'h0000, 0);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s0_run_len", 64'(n), 64'(e0.len));
        chk("s0_pass", 64'(pass1), 64'd1);
        chk("s0_fail_cnt", 64'(fcnt1), 64'(e0.fail));
        chk("s0_first", 64'(ffv1), 64'(e0.first));
        chk("s0_sig", 64'(sig1), 64'(e0.sig));

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
